// File: rtl/edge_generator.sv
// rtl/edge_generator.sv - edge/pulse transmitter with minimum high/low hold times and one-deep pending slot
module edge_generator #(
  parameter int MIN_HIGH = 4,
  parameter int MIN_LOW  = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             risereq,
  input  logic             fallreq,
  input  logic             togglereq,
  input  logic             pulsereq,
  input  logic [CNT_W-1:0] pulselen,
  output logic             out,
  output logic             ack,
  output logic             dropped,
  output logic             busy
);

  typedef enum logic [2:0] {
    ST_LOW,
    ST_LOWHOLD,
    ST_HIGH,
    ST_HIGHHOLD,
    ST_PULSE
  } state_t;

  typedef enum logic [2:0] {
    REQ_NONE,
    REQ_FALL,
    REQ_RISE,
    REQ_TOGGLE,
    REQ_PULSE
  } req_t;

  localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(MIN_HIGH - 1);
  localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(MIN_LOW - 1);
  localparam logic [CNT_W-1:0] MIN_HIGH_C = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);

  state_t           state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic             pend_valid, nxt_pend_valid;
  req_t             pend_type, nxt_pend_type;
  logic [CNT_W-1:0] pend_len, nxt_pend_len;
  logic             nxt_ack, nxt_dropped;

  req_t             fresh_req;
  logic             eval_en, eval_high, eval_ack_en, store_en;
  req_t             eval_req;
  logic [CNT_W-1:0] eval_len, eff_len;

  // Resolve simultaneous strobes: pulse > toggle > rise > fall, losers vanish
  always_comb begin
    fresh_req = REQ_NONE;
    if (pulsereq)       fresh_req = REQ_PULSE;
    else if (togglereq) fresh_req = REQ_TOGGLE;
    else if (risereq)   fresh_req = REQ_RISE;
    else if (fallreq)   fresh_req = REQ_FALL;
  end

  // Pulse length clamped up to the minimum high time (covers pulselen=0 as well)
  always_comb begin
    eff_len = (eval_len < MIN_HIGH_C) ? MIN_HIGH_C : eval_len;
  end

  // Next-state logic: hold countdown, expiry, pending slot, idle evaluation
  always_comb begin
    nxt_state      = state;
    nxt_cnt        = cnt;
    nxt_pend_valid = pend_valid;
    nxt_pend_type  = pend_type;
    nxt_pend_len   = pend_len;
    nxt_ack        = 1'b0;
    nxt_dropped    = 1'b0;
    eval_en        = 1'b0;
    eval_high      = 1'b0;
    eval_ack_en    = 1'b0;
    eval_req       = REQ_NONE;
    eval_len       = '0;
    store_en       = 1'b0;

    case (state)
      ST_LOW, ST_HIGH: begin
        eval_en     = 1'b1;
        eval_high   = (state == ST_HIGH);
        eval_ack_en = 1'b1;
        eval_req    = fresh_req;
        eval_len    = pulselen;
      end
      ST_LOWHOLD, ST_HIGHHOLD: begin
        if (cnt != '0) begin
          nxt_cnt  = cnt - ONE_C;
          store_en = 1'b1;
        end else begin
          // Expiry: settle to the idle level, then act on the next request in the same cycle
          eval_en   = 1'b1;
          eval_high = (state == ST_HIGHHOLD);
          nxt_state = eval_high ? ST_HIGH : ST_LOW;
          if (pend_valid) begin
            nxt_pend_valid = 1'b0;
            eval_req       = pend_type;
            eval_len       = pend_len;
            // A fresh request cannot be queued behind the one being consumed
            nxt_dropped    = (fresh_req != REQ_NONE);
          end else begin
            eval_ack_en = 1'b1;
            eval_req    = fresh_req;
            eval_len    = pulselen;
          end
        end
      end
      ST_PULSE: begin
        store_en = 1'b1;
        if (cnt != '0) begin
          nxt_cnt = cnt - ONE_C;
        end else begin
          // A pulse always ends by falling; any pending request waits out the low hold
          nxt_state = ST_LOWHOLD;
          nxt_cnt   = LOW_LOAD;
        end
      end
      default: begin
        nxt_state = ST_LOW;
        nxt_cnt   = '0;
      end
    endcase

    if (store_en && fresh_req != REQ_NONE) begin
      if (!pend_valid) begin
        nxt_pend_valid = 1'b1;
        nxt_pend_type  = fresh_req;
        nxt_pend_len   = pulselen;
        nxt_ack        = 1'b1;
      end else begin
        nxt_dropped = 1'b1;
      end
    end

    if (eval_en) begin
      if (!eval_high) begin
        case (eval_req)
          REQ_RISE, REQ_TOGGLE: begin
            nxt_state = ST_HIGHHOLD;
            nxt_cnt   = HIGH_LOAD;
            nxt_ack   = eval_ack_en;
          end
          REQ_PULSE: begin
            nxt_state = ST_PULSE;
            nxt_cnt   = eff_len - ONE_C;
            nxt_ack   = eval_ack_en;
          end
          REQ_FALL: nxt_ack = eval_ack_en;
          default: ;
        endcase
      end else begin
        case (eval_req)
          REQ_FALL, REQ_TOGGLE: begin
            nxt_state = ST_LOWHOLD;
            nxt_cnt   = LOW_LOAD;
            nxt_ack   = eval_ack_en;
          end
          REQ_RISE:  nxt_ack     = eval_ack_en;
          REQ_PULSE: nxt_dropped = 1'b1;
          default: ;
        endcase
      end
    end
  end

  // State, counter, pending slot and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_LOW;
      cnt        <= '0;
      pend_valid <= 1'b0;
      pend_type  <= REQ_NONE;
      pend_len   <= '0;
      out        <= 1'b0;
      ack        <= 1'b0;
      dropped    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= nxt_state;
      cnt        <= nxt_cnt;
      pend_valid <= nxt_pend_valid;
      pend_type  <= nxt_pend_type;
      pend_len   <= nxt_pend_len;
      out        <= (nxt_state == ST_HIGH) || (nxt_state == ST_HIGHHOLD) || (nxt_state == ST_PULSE);
      ack        <= nxt_ack;
      dropped    <= nxt_dropped;
      busy       <= !((nxt_state == ST_LOW) || (nxt_state == ST_HIGH)) || nxt_pend_valid;
    end
  end

endmodule

// File: tb/tb_edge_generator.sv
// tb/tb_edge_generator.sv - randomized self-checking bench for edge_generator against a timeline model
module tb_edge_generator;

  localparam int MIN_HIGH = 4;
  localparam int MIN_LOW  = 4;
  localparam int CNT_W    = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             risereq = 1'b0, fallreq = 1'b0, togglereq = 1'b0, pulsereq = 1'b0;
  logic [CNT_W-1:0] pulselen = '0;
  logic             out, ack, dropped, busy;

  int n_tests = 0;
  int n_fail  = 0;

  edge_generator #(.MIN_HIGH(MIN_HIGH), .MIN_LOW(MIN_LOW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .risereq(risereq), .fallreq(fallreq),
    .togglereq(togglereq), .pulsereq(pulsereq), .pulselen(pulselen),
    .out(out), .ack(ack), .dropped(dropped), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: level plus time of the last edge and the gap that edge demands.
  // Codes: 0 none, 1 fall, 2 rise, 3 toggle, 4 pulse.
  longint t_now;
  longint edge_t;
  int     gap;
  bit     lvl, in_pulse;
  int     pend_req[$];
  int     pend_len[$];
  bit     e_ack, e_drop, e_busy;

  task automatic model_reset();
    lvl = 0; in_pulse = 0; gap = MIN_LOW; edge_t = t_now - 1000;
    pend_req.delete(); pend_len.delete();
  endtask

  task automatic make_edge(input bit new_lvl, input int new_gap, input bit is_pulse);
    lvl = new_lvl; edge_t = t_now + 1; gap = new_gap; in_pulse = is_pulse;
  endtask

  task automatic model_exec(input int req, input int len, input bit acks);
    if (!lvl) begin
      if (req == 2 || req == 3) begin make_edge(1, MIN_HIGH, 0); if (acks) e_ack = 1; end
      else if (req == 4) begin make_edge(1, (len > MIN_HIGH) ? len : MIN_HIGH, 1); if (acks) e_ack = 1; end
      else if (req == 1 && acks) e_ack = 1;
    end else begin
      if (req == 1 || req == 3) begin make_edge(0, MIN_LOW, 0); if (acks) e_ack = 1; end
      else if (req == 2 && acks) e_ack = 1;
      else if (req == 4) e_drop = 1;
    end
  endtask

  task automatic model_store(input int req, input int len);
    if (req == 0) return;
    if (pend_req.size() == 0) begin pend_req.push_back(req); pend_len.push_back(len); e_ack = 1; end
    else e_drop = 1;
  endtask

  task automatic model_step(input int req, input int len);
    longint elapsed;
    int p, pl;
    e_ack = 0; e_drop = 0;
    elapsed = t_now - edge_t;
    if (elapsed >= gap) model_exec(req, len, 1);
    else if (elapsed < gap - 1) model_store(req, len);
    else if (in_pulse) begin
      make_edge(0, MIN_LOW, 0);
      model_store(req, len);
    end else if (pend_req.size() != 0) begin
      p = pend_req.pop_front(); pl = pend_len.pop_front();
      model_exec(p, pl, 0);
      if (req != 0) e_drop = 1;
    end else model_exec(req, len, 1);
    t_now++;
    e_busy = ((t_now - edge_t) < gap) || (pend_req.size() != 0);
  endtask

  task automatic step(input bit p, input bit tg, input bit r, input bit f, input int len);
    int req;
    pulsereq = p; togglereq = tg; risereq = r; fallreq = f; pulselen = len[CNT_W-1:0];
    req = p ? 4 : tg ? 3 : r ? 2 : f ? 1 : 0;
    model_step(req, len & ((1 << CNT_W) - 1));
    @(posedge clk); #1;
    check("out", out, lvl);
    check("ack", ack, e_ack);
    check("dropped", dropped, e_drop);
    check("busy", busy, e_busy);
    check("no_x", $isunknown({out, ack, dropped, busy}), 0);
    pulsereq = 0; togglereq = 0; risereq = 0; fallreq = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hi;
    t_now = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", out, 0);
    check("rst_busy", busy, 0);
    check("rst_ack", ack, 0);
    rst_n = 1;

    // Idle after reset
    idle(20);

    // Rise then a fall queued behind the high hold
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    idle(10);

    // Long and short pulses, width measured directly
    step(1, 0, 0, 0, 10);
    hi = 0;
    while (out === 1'b1 && hi < 300) begin hi++; step(0, 0, 0, 0, 0); end
    check("pulse10_width", hi, 10);
    idle(8);
    step(1, 0, 0, 0, 2);
    hi = 0;
    while (out === 1'b1 && hi < 300) begin hi++; step(0, 0, 0, 0, 0); end
    check("pulse2_width", hi, MIN_HIGH);
    step(0, 0, 1, 0, 0);
    idle(10);

    // Toggle stored, rise dropped while in the high hold
    step(0, 0, 0, 1, 0);
    idle(6);
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    idle(10);

    // Simultaneous requests from LOW, then pulse from HIGH
    step(1, 0, 1, 1, 5);
    idle(12);
    step(0, 0, 1, 0, 0);
    idle(6);
    step(1, 0, 0, 0, 7);
    idle(4);

    // Async reset in the middle of a pulse with a pending request held
    step(0, 0, 0, 1, 0);
    idle(6);
    step(1, 0, 0, 0, 20);
    idle(2);
    step(0, 0, 1, 0, 0);
    #2 rst_n = 0;
    #1;
    check("async_rst_out", out, 0);
    check("async_rst_busy", busy, 0);
    @(posedge clk); #1;
    check("rst_hold_out", out, 0);
    rst_n = 1;
    model_reset();
    idle(25);

    // Randomized traffic at several request densities and pulse lengths
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 800; i++) begin
        int den;
        int len;
        den = (ph == 0) ? 3 : (ph == 1) ? 10 : (ph == 2) ? 30 : 60;
        len = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
        step($urandom_range(0, 99) < den / 2, $urandom_range(0, 99) < den,
             $urandom_range(0, 99) < den, $urandom_range(0, 99) < den, len);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
